mem_port_arbiter: RTL and testbench

Registered N-channel arbiter for one single-port on-chip RAM (S-box / message / result memories of the ARC4 datapath). Each loop engine (init, swap, decrypt) is a channel with a request/grant handshake. The block sequences ownership through the channels in phase order via per-channel done pulses. It also routes read data back to the channel that issued each read, accounting for the RAM's read latency.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_port_arbiter_rd_tag_pipe.sv | 27 ++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: FSM states, read-return tag, id width.
// Optional round-robin arbitration is selected with MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int N_CH_MAX = 8;
  // Tag ids are sized for the largest supported channel count so the struct
  // stays parameter-free; the top level uses only the low $clog2(N_CH) bits.
  localparam int ID_W = $clog2(N_CH_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Channel-side request/grant/read-return bus plus the single RAM port.
// The slave modport is the arbiter; master is the engines plus RAM.
interface mem_port_arbiter_if #(
  parameter int N_CH = 3,
  parameter int AW   = 8,
  parameter int DW   = 8
);

  logic [N_CH-1:0]    ch_req;
  logic [N_CH-1:0]    ch_wren;
  logic [N_CH*AW-1:0] ch_addr;
  logic [N_CH*DW-1:0] ch_wdata;
  logic [N_CH-1:0]    ch_gnt;
  logic [N_CH-1:0]    ch_rvalid;
  logic [DW-1:0]      ch_rdata;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_wren;
  logic [DW-1:0]      mem_rdata;

  modport slave (
    input  ch_req, ch_wren, ch_addr, ch_wdata, mem_rdata,
    output ch_gnt, ch_rvalid, ch_rdata, mem_addr, mem_wdata, mem_wren
  );

  modport master (
    output ch_req, ch_wren, ch_addr, ch_wdata, mem_rdata,
    input  ch_gnt, ch_rvalid, ch_rdata, mem_addr, mem_wdata, mem_wren
  );

endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register carrying {valid, id} read tags alongside the
// RAM read latency; synchronous clear drops every tag in flight.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    i_clr,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Phase-sequenced arbiter for one single-port RAM with per-channel read return.
// Define MEM_ARB_RR_EN for round-robin grants among all requesters in RUN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH   = 3,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [N_CH-1:0] ch_done,
  mem_port_arbiter_if.slave bus,
  output logic [2:0]      phase,
  output logic            busy,
  output logic            all_done
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // RUN   | channel `phase` owns the RAM port
  // DONE  | last phase finished, waiting for start
  localparam int IW = $clog2(N_CH);

  arb_state_e      r_state, w_state_nxt;
  logic [2:0]      r_phase, w_phase_nxt;
  logic [IW-1:0]   w_owner;
  logic [IW-1:0]   w_win_id;
  logic            w_grant_any;
  logic [N_CH-1:0] w_gnt;
  logic [N_CH-1:0] w_rvalid;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_mem_wren;
  rd_tag_t         r_issue;
  rd_tag_t         w_tail;

  assign w_owner = r_phase[IW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_phase_nxt = '0;
        end
      end
      RUN: begin
        if (ch_done[w_owner]) begin
          if (r_phase == 3'(N_CH-1)) w_state_nxt = DONE;
          else                       w_phase_nxt = r_phase + 3'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] r_rr_ptr;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    return IW'((int'(base) + off) % N_CH);
  endfunction

  // First requester at or after the pointer wins.
  always_comb begin
    w_gnt       = '0;
    w_win_id    = r_rr_ptr;
    w_grant_any = 1'b0;
    if (r_state == RUN) begin
      for (int i = 0; i < N_CH; i++) begin
        if (!w_grant_any && bus.ch_req[rr_idx(r_rr_ptr, i)]) begin
          w_grant_any = 1'b1;
          w_win_id    = rr_idx(r_rr_ptr, i);
        end
      end
    end
    if (w_grant_any) w_gnt[w_win_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)            r_rr_ptr <= '0;
    else if (w_grant_any) r_rr_ptr <= rr_idx(w_win_id, 1);
  end
`else
  always_comb begin
    w_gnt          = '0;
    w_win_id       = w_owner;
    w_grant_any    = (r_state == RUN) && bus.ch_req[w_owner];
    w_gnt[w_owner] = w_grant_any;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wren  <= 1'b0;
      r_issue     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_mem_wren    <= 1'b0;
      r_issue.valid <= 1'b0;
      if (w_grant_any) begin
        r_mem_addr  <= bus.ch_addr[w_win_id*AW +: AW];
        r_mem_wdata <= bus.ch_wdata[w_win_id*DW +: DW];
        r_mem_wren  <= bus.ch_wren[w_win_id];
        r_issue     <= '{valid: !bus.ch_wren[w_win_id], id: ID_W'(w_win_id)};
      end
    end
  end

  // r_issue adds the cycle in which mem_addr is presented; the pipe covers RD_LAT.
  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk   (clk),
    .i_clr (reset),
    .i_tag (r_issue),
    .o_tag (w_tail)
  );

  always_comb begin
    w_rvalid = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_rvalid[i] = w_tail.valid && (w_tail.id == ID_W'(i));
    end
  end

  assign bus.ch_gnt    = w_gnt;
  assign bus.ch_rvalid = w_rvalid;
  assign bus.ch_rdata  = w_tail.valid ? bus.mem_rdata : '0;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wren  = r_mem_wren;
  assign phase         = r_phase;
  assign busy          = (r_state == RUN);
  assign all_done      = (r_state == DONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a RAM model and a read-return scoreboard.
module tb_mem_port_arbiter;

  localparam int N_CH   = 3;
  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int RD_LAT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [N_CH-1:0] ch_done;
  logic [2:0]      phase;
  logic            busy;
  logic            all_done;

  mem_port_arbiter_if #(.N_CH(N_CH), .AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ch_done  (ch_done),
    .bus      (bus),
    .phase    (phase),
    .busy     (busy),
    .all_done (all_done)
  );

  always #5 clk = ~clk;

  // RAM: data for the address presented in cycle c appears in cycle c+RD_LAT.
  logic [DW-1:0] ram [256];
  logic [AW-1:0] a_pipe [RD_LAT];
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    a_pipe[0] <= bus.mem_addr;
    for (int i = 1; i < RD_LAT; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign bus.mem_rdata = ram[a_pipe[RD_LAT-1]];

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] shadow [256];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read-return monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      if (bus.ch_rvalid !== '0) begin
        if (q.size() == 0) begin
          check("rd_unexpected", 32'(bus.ch_rvalid), 32'd0);
        end else begin
          e = q.pop_front();
          check("rd_valid", 32'(bus.ch_rvalid), 32'(1 << e.ch));
          check("rd_data", 32'(bus.ch_rdata), 32'(e.data));
          check("rd_cycle", cyc, e.due);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        check("rd_missing", 32'(bus.ch_rvalid), 32'(1 << q[0].ch));
        void'(q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int ch, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [N_CH-1:0] exp_gnt);
    bus.ch_req[ch]              = 1'b1;
    bus.ch_wren[ch]             = wr;
    bus.ch_addr[ch*AW +: AW]    = addr;
    bus.ch_wdata[ch*DW +: DW]   = data;
    #1;
    check("gnt", 32'(bus.ch_gnt), 32'(exp_gnt));
    tick(1);
    bus.ch_req[ch]  = 1'b0;
    bus.ch_wren[ch] = 1'b0;
    if (exp_gnt[ch]) begin
      check("mem_wren", 32'(bus.mem_wren), 32'(wr));
      check("mem_addr", 32'(bus.mem_addr), 32'(addr));
      if (wr) begin
        check("mem_wdata", 32'(bus.mem_wdata), 32'(data));
        shadow[addr] = data;
      end else begin
        q.push_back('{ch: ch, data: shadow[addr], due: cyc + RD_LAT});
      end
    end else begin
      check("mem_wren_nogrant", 32'(bus.mem_wren), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    ch_done      = '0;
    bus.ch_req   = '0;
    bus.ch_wren  = '0;
    bus.ch_addr  = '0;
    bus.ch_wdata = '0;
    tick(2);

    bus.ch_req = 3'b001;
    #1;
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_all_done", 32'(all_done), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
    check("rst_rvalid", 32'(bus.ch_rvalid), 32'd0);
    check("rst_rdata", 32'(bus.ch_rdata), 32'd0);
    check("rst_gnt", 32'(bus.ch_gnt), 32'd0);

    reset = 1'b0;
    tick(1);
    check("idle_gnt", 32'(bus.ch_gnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    bus.ch_req = '0;
    mon_en     = 1'b1;

    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_phase", 32'(phase), 32'd0);

`ifdef MEM_ARB_RR_EN
    bus.ch_req   = 3'b111;
    bus.ch_wren  = 3'b111;
    bus.ch_addr  = {8'h22, 8'h21, 8'h20};
    bus.ch_wdata = {8'h52, 8'h51, 8'h50};
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_gnt", 32'(bus.ch_gnt), 32'(1 << (k % N_CH)));
      tick(1);
      check("rr_mem_addr", 32'(bus.mem_addr), 32'h20 + 32'(k % N_CH));
      check("rr_mem_wdata", 32'(bus.mem_wdata), 32'h50 + 32'(k % N_CH));
      shadow[8'h20 + 8'(k % N_CH)] = 8'h50 + 8'(k % N_CH);
    end
    bus.ch_req  = '0;
    bus.ch_wren = '0;
`else
    bus.ch_req[1]   = 1'b1;
    bus.ch_addr[15:8] = 8'h05;
    #1;
    check("nonowner_gnt", 32'(bus.ch_gnt), 32'd0);
    tick(1);
    check("nonowner_mem_wren", 32'(bus.mem_wren), 32'd0);
    check("nonowner_mem_addr", 32'(bus.mem_addr), 32'd0);
    bus.ch_req = '0;
`endif

    issue(0, 1'b1, 8'h05, 8'hA5, 3'b001);
    tick(1);
    check("idle_wren", 32'(bus.mem_wren), 32'd0);
    check("hold_addr", 32'(bus.mem_addr), 32'h05);
    check("hold_wdata", 32'(bus.mem_wdata), 32'hA5);

    issue(0, 1'b0, 8'h05, 8'h00, 3'b001);
    tick(3);

    issue(0, 1'b1, 8'h10, 8'h3C, 3'b001);
    issue(0, 1'b0, 8'h10, 8'h00, 3'b001);
    issue(0, 1'b0, 8'h05, 8'h00, 3'b001);
    tick(4);

    ch_done = 3'b100;
    tick(1);
    ch_done = '0;
    check("nonowner_done_phase", 32'(phase), 32'd0);
    check("nonowner_done_busy", 32'(busy), 32'd1);

    ch_done = 3'b001;
    issue(0, 1'b0, 8'h10, 8'h00, 3'b001);
    ch_done = '0;
    check("phase1", 32'(phase), 32'd1);

    issue(1, 1'b0, 8'h05, 8'h00, 3'b010);
`ifndef MEM_ARB_RR_EN
    issue(0, 1'b0, 8'h05, 8'h00, 3'b000);
`endif
    tick(3);

    ch_done = 3'b010;
    tick(1);
    ch_done = '0;
    check("phase2", 32'(phase), 32'd2);

    issue(2, 1'b1, 8'h33, 8'h77, 3'b100);
    ch_done = 3'b100;
    tick(1);
    ch_done = '0;
    check("done_all_done", 32'(all_done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);

    bus.ch_req = 3'b001;
    #1;
    check("done_gnt", 32'(bus.ch_gnt), 32'd0);
    tick(2);
    bus.ch_req = '0;
    check("done_hold", 32'(all_done), 32'd1);
    check("done_mem_wren", 32'(bus.mem_wren), 32'd0);

    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_phase", 32'(phase), 32'd0);
    check("restart_all_done", 32'(all_done), 32'd0);

    issue(0, 1'b0, 8'h33, 8'h00, 3'b001);
    tick(3);

    issue(0, 1'b0, 8'h05, 8'h00, 3'b001);
    reset = 1'b1;
    q.delete();
    tick(1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_phase", 32'(phase), 32'd0);
    check("mid_rst_all_done", 32'(all_done), 32'd0);
    check("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("mid_rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("mid_rst_mem_wren", 32'(bus.mem_wren), 32'd0);
    check("mid_rst_rvalid", 32'(bus.ch_rvalid), 32'd0);
    check("mid_rst_rdata", 32'(bus.ch_rdata), 32'd0);
    reset = 1'b0;
    tick(4);
    check("post_rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
    check("rd_drain", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
